// File: rtl/or_bus_if.sv
// Command/response handshakes plus the 3-bit register bus of the OR-combiner.
// master: the initiator side. slave: the environment (command source, response
// sink, register port).
interface or_bus_if;
  // command port
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  // response port
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  // register bus, write side
  logic [2:0] write_address;
  logic [7:0] write_data;
  logic       write_en;
  logic       write_rdy;
  // register bus, read side; read_data follows read_address combinationally
  logic [2:0] read_address;
  logic       read_en;
  logic [7:0] read_data;
  logic       read_rdy;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, rsp_ready, write_rdy, read_data, read_rdy,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
    output write_address, write_data, write_en, read_address, read_en
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, rsp_ready, write_rdy, read_data, read_rdy,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
    input  write_address, write_data, write_en, read_address, read_en
  );
endinterface

// File: rtl/or_bus_initiator.sv
// Bus master for the OR-combiner register port. Takes an (a, b) pair, writes a
// to address 4 and b to address 5 once their FIFOs report space, polls the
// result status, pops the result from address 3 and returns it. The result
// wait is bounded by TIMEOUT cycles; on expiry an error response (data 0) is
// returned and the late result is left in the FIFO for the next transaction.
//
// Register map seen by this block:
//   0 : status of operand FIFO a (bit0 = not full)  -- never read_en here
//   1 : status of operand FIFO b (bit0 = not full)
//   2 : status of result FIFO    (bit0 = not empty)
//   3 : result data; read_en pops it
//   4 : operand a write
//   5 : operand b write
module or_bus_initiator #(
  // TIMEOUT must exceed 256: the combiner emits one result per 8-bit wrap.
  parameter int TIMEOUT = 512,
  // 2**TO_W must exceed TIMEOUT.
  parameter int TO_W    = 10
) (
  input  logic        CLK,
  input  logic        RST,
  or_bus_if.master    bus,
  output logic        busy,
  output logic [15:0] txn_count
);

  localparam logic [2:0] ADDR_ST_A = 3'd0;
  localparam logic [2:0] ADDR_ST_B = 3'd1;
  localparam logic [2:0] ADDR_ST_Y = 3'd2;
  localparam logic [2:0] ADDR_Y    = 3'd3;
  localparam logic [2:0] ADDR_A    = 3'd4;
  localparam logic [2:0] ADDR_B    = 3'd5;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, POLL_A, WR_A, POLL_B, WR_B, POLL_Y, RD_Y, RESP
  } state_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } opnd_t;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } rsp_t;

  state_t          state, state_nx;
  opnd_t           opnd;
  rsp_t            rsp;
  logic [TO_W-1:0] to_cnt;

  // decoded bus conditions
  logic wr_go;    // polled operand FIFO has space and the bus takes a write
  logic y_go;     // result present and the bus takes a read
  logic to_hit;   // last allowed POLL_Y cycle

  // combinational bus/handshake drives, copied onto the interface below
  logic       cmd_ready_c;
  logic       rsp_valid_c;
  logic [2:0] wr_addr_c;
  logic [7:0] wr_data_c;
  logic       wr_en_c;
  logic [2:0] rd_addr_c;
  logic       rd_en_c;

  assign wr_go  = bus.read_data[0] & bus.write_rdy;
  assign y_go   = bus.read_data[0] & bus.read_rdy;
  assign to_hit = (to_cnt == TO_LAST);

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and per-state bus drives; everything idles at 0 by default.
  always_comb begin
    state_nx    = state;
    cmd_ready_c = 1'b0;
    rsp_valid_c = 1'b0;
    wr_addr_c   = 3'd0;
    wr_data_c   = 8'd0;
    wr_en_c     = 1'b0;
    rd_addr_c   = 3'd0;
    rd_en_c     = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready_c = 1'b1;
        if (bus.cmd_valid) state_nx = POLL_A;
      end
      POLL_A: begin
        // status only: read_en at address 0 would pop operand FIFO a
        rd_addr_c = ADDR_ST_A;
        if (wr_go) state_nx = WR_A;
      end
      WR_A: begin
        wr_addr_c = ADDR_A;
        wr_data_c = opnd.a;
        wr_en_c   = 1'b1;
        state_nx  = POLL_B;
      end
      POLL_B: begin
        rd_addr_c = ADDR_ST_B;
        if (wr_go) state_nx = WR_B;
      end
      WR_B: begin
        wr_addr_c = ADDR_B;
        wr_data_c = opnd.b;
        wr_en_c   = 1'b1;
        state_nx  = POLL_Y;
      end
      POLL_Y: begin
        rd_addr_c = ADDR_ST_Y;
        // a result arriving on the expiry cycle still wins
        if (y_go)        state_nx = RD_Y;
        else if (to_hit) state_nx = RESP;
      end
      RD_Y: begin
        rd_addr_c = ADDR_Y;
        rd_en_c   = 1'b1;
        state_nx  = RESP;
      end
      RESP: begin
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand latch, timeout counter, response register and transaction count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      opnd      <= '0;
      rsp       <= '0;
      to_cnt    <= '0;
      txn_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) opnd <= '{a: bus.cmd_a, b: bus.cmd_b};
        end
        WR_B: begin
          to_cnt <= '0;
        end
        POLL_Y: begin
          to_cnt <= to_cnt + 1'b1;
          if (!y_go && to_hit) rsp <= '{err: 1'b1, data: 8'h00};
        end
        RD_Y: begin
          // read_data is combinational on address 3 during this cycle
          rsp <= '{err: 1'b0, data: bus.read_data};
        end
        RESP: begin
          if (bus.rsp_ready) txn_count <= txn_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready     = cmd_ready_c;
  assign bus.rsp_valid     = rsp_valid_c;
  assign bus.rsp_data      = rsp.data;
  assign bus.rsp_err       = rsp.err;
  assign bus.write_address = wr_addr_c;
  assign bus.write_data    = wr_data_c;
  assign bus.write_en      = wr_en_c;
  assign bus.read_address  = rd_addr_c;
  assign bus.read_en       = rd_en_c;
  assign busy              = (state != IDLE);

endmodule

// File: doc/or_bus_initiator.md
Name: or_bus_initiator

Overview:
- Bus master for the 3-bit-address register port of the OR-combiner block.
- Accepts (a, b) operand pairs on a valid/ready command port and writes a to address 4 and b to address 5, each only after its status shows the target FIFO is not full.
- Polls the result-ready status, reads the combined result from address 3, and returns it on a valid/ready response port.
- A configurable timeout guards the wait on the result FIFO.

Parameters:
- TIMEOUT, 512, maximum POLL_Y cycles before aborting. Must exceed 256 because the result is produced only once per 8-bit counter wrap.
- TO_W, 10, width of the timeout counter. Must satisfy 2^TO_W > TIMEOUT.

Ports:
- CLK  input  1  clock; all logic on rising edge
- RST  input  1  synchronous, active-high reset
- cmd_valid  input  1  operand pair present
- cmd_ready  output  1  initiator can accept a pair
- cmd_a  input  8  operand a
- cmd_b  input  8  operand b
- rsp_valid  output  1  result present
- rsp_ready  input  1  consumer accepts result
- rsp_data  output  8  a|b result, or 0 on error
- rsp_err  output  1  result-wait timed out
- write_address  output  3  bus write address
- write_data  output  8  bus write data
- write_en  output  1  bus write strobe, one cycle per write
- write_rdy  input  1  bus accepts a write this cycle
- read_address  output  3  bus read address; read_data is combinational on it
- read_en  output  1  read strobe; pops the FIFO at address 3
- read_data  input  8  bus read data
- read_rdy  input  1  bus accepts a read this cycle
- busy  output  1  FSM not in IDLE
- txn_count  output  16  completed transactions (ok + err), wraps

Behaviour:
- Reset (sync, RST=1 at a rising edge):
  - state=IDLE.
  - All outputs 0 except cmd_ready=1.
  - read_address=0; operand, timeout and txn_count registers cleared.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch cmd_a/cmd_b and go to POLL_A. cmd_ready is 1 only in IDLE.
- POLL_A:
  - read_address=0, read_en=0. read_en must never be asserted at address 0, because that pops operand FIFO a.
  - If read_data[0]=1 and write_rdy=1, go to WR_A; else stay.
- WR_A:
  - write_address=4, write_data=a, write_en=1 for exactly one cycle.
  - Go to POLL_B.
- POLL_B:
  - read_address=1, read_en=0.
  - If read_data[0]=1 and write_rdy=1, go to WR_B.
- WR_B:
  - write_address=5, write_data=b, write_en=1 for one cycle.
  - Clear the timeout counter and go to POLL_Y.
- POLL_Y:
  - read_address=2, read_en=0; increment the timeout counter each cycle.
  - If read_data[0]=1 and read_rdy=1, go to RD_Y. This takes priority if it coincides with timeout expiry.
  - Else, if count reaches TIMEOUT-1, latch rsp_data=0, rsp_err=1 and go to RESP.
- RD_Y:
  - read_address=3, read_en=1 for exactly one cycle.
  - read_data is sampled at the same edge into rsp_data, with rsp_err=0.
  - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err held stable until rsp_ready.
  - On rsp_valid&rsp_ready: increment txn_count (0xFFFF wraps to 0) and go to IDLE.
  - The next cmd is accepted no earlier than the cycle after the handshake.
- Bus signals in non-driving states:
  - write_en=0 and read_en=0 outside WR_*/RD_Y.
  - write_address/write_data are 0 when write_en=0.
- Minimum latency, cmd handshake to rsp_valid, with all status bits already 1: 6 cycles (POLL_A, WR_A, POLL_B, WR_B, POLL_Y, RD_Y).
- After a timeout, the late y element remains in the downstream FIFO. The next transaction reads it; there is no flush.
- Reset mid-operation: abort immediately to IDLE. A partially issued write is not retried.

Test Plan:
- Latency: status bits all 1, cmd a=0x0F b=0xF0; addr3 returns 0xFF → writes (4,0x0F) then (5,0xF0), one read_en at addr 3, rsp_data=0xFF, rsp_err=0, rsp_valid 6 cycles after the cmd handshake, txn_count=1.
- Backpressure on a: addr0 status=0 for 20 cycles, then 1 → no write_en and no read_en during the stall; write (4,a) follows on the cycle after status rises.
- Timeout: addr2 status held 0 → exactly TIMEOUT=512 POLL_Y cycles, then rsp_valid with rsp_data=0x00, rsp_err=1, read_en never asserted.
- Response hold: rsp_ready=0 for 10 cycles with result 0x3C → rsp_data stays 0x3C, cmd_ready=0, txn_count increments only at the handshake.
- Reset mid-op: assert RST for 1 cycle in POLL_Y → next cycle busy=0, cmd_ready=1, txn_count=0, no rsp_valid.
- Back-to-back: pairs (0x01,0x02) and (0x10,0x20), rsp_ready tied 1 → responses 0x03 then 0x30 in order, txn_count=2, exactly 4 write_en pulses.
